// File: rtl/heard_word_serializer_pkg.sv
// Shared types and constants for the heard-indication word serializer.
package heard_word_serializer_pkg;

    // One buffered indication: the two fields of the heard method.
    typedef struct packed {
        logic [31:0] meth;
        logic [31:0] v;
    } heard_msg_t;

    // Word index within a message (IDLE is implied by an empty FIFO).
    localparam logic [1:0] WIDX_HDR = 2'd0;
    localparam logic [1:0] WIDX_MSG = 2'd1;
    localparam logic [1:0] WIDX_VAL = 2'd2;

    // Every message is a header plus the two payload fields.
    localparam int          MSG_WORDS = 3;
    localparam logic [15:0] HDR_LEN   = 16'd3;

    // Header word: message length in the upper half, method index in the lower.
    function automatic logic [31:0] header_word(input logic [15:0] method_id);
        return {HDR_LEN, method_id};
    endfunction

endpackage

// File: rtl/heard_word_serializer_msg_fifo.sv
// Generic DEPTH-entry register FIFO of heard messages with full/empty flags.
// Callers must not push while full or pop while empty.
module heard_word_serializer_msg_fifo
    import heard_word_serializer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  heard_msg_t i_wdata,
    input  logic       i_pop,
    output heard_msg_t o_rdata,
    output logic       o_full,
    output logic       o_empty
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

    heard_msg_t    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    // Write the pushed message into storage.
    // NOTE: storage carries no reset; the count decides which entries are valid,
    // so clearing the array would only add reset fan-out for no behavioural gain.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Advance pointers (natural wrap at DEPTH) and track occupancy.
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/heard_word_serializer.sv
// Buffers heard indications and streams each one to the host as three
// 32-bit words: header, meth, v. Host backpressure never stalls the
// indication side until the FIFO is full.
module heard_word_serializer
    import heard_word_serializer_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [15:0] METHOD_ID = 16'h0001
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        indication_heard__ENA,
    input  logic [31:0] indication_heard_meth,
    input  logic [31:0] indication_heard_v,
    output logic        indication_heard__RDY,
    output logic        word__ENA,
    output logic [31:0] word_data,
    output logic        word_last,
    input  logic        word__RDY,
    output logic        err_overflow
);

    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic       w_xfer;
    heard_msg_t w_wdata;
    heard_msg_t w_head;

    logic [1:0] r_widx;
    logic       r_overflow;

    // Ready depends only on registered occupancy, so a full FIFO never
    // sees a push and a pop on the same edge.
    assign indication_heard__RDY = !w_full;
    assign w_push                = indication_heard__ENA && !w_full;
    assign w_wdata               = '{meth: indication_heard_meth, v: indication_heard_v};

    // A word moves whenever something is queued and the host is ready.
    assign w_xfer    = !w_empty && word__RDY;
    assign word__ENA = w_xfer;
    assign w_pop     = w_xfer && (r_widx == WIDX_VAL);

    heard_word_serializer_msg_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (nRST),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Word-index FSM: HDR -> MSG -> VAL on transfers only; wraps to HDR after
    // the popping VAL word. IDLE is simply "FIFO empty" with the index at HDR.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_widx <= WIDX_HDR;
        end else if (w_xfer) begin
            case (r_widx)
                WIDX_HDR: r_widx <= WIDX_MSG;
                WIDX_MSG: r_widx <= WIDX_VAL;
                default:  r_widx <= WIDX_HDR;
            endcase
        end
    end

    // Sticky overflow: an enqueue attempted while not ready.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_overflow <= 1'b0;
        end else if (indication_heard__ENA && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign err_overflow = r_overflow;

    // Select the word presented to the host; zero while nothing is queued.
    // NOTE: both outputs get a default first so no path leaves them unassigned.
    always_comb begin
        word_data = '0;
        word_last = 1'b0;
        if (!w_empty) begin
            case (r_widx)
                WIDX_HDR: word_data = header_word(METHOD_ID);
                WIDX_MSG: word_data = w_head.meth;
                WIDX_VAL: begin
                    word_data = w_head.v;
                    word_last = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_heard_word_serializer.sv
// Randomized bench for heard_word_serializer against a queue-based message model.
module tb_heard_word_serializer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] HDR   = 32'h0003_0001;

    logic        clk        = 1'b0;
    logic        n_rst      = 1'b0;
    logic        heard_ena  = 1'b0;
    logic [31:0] heard_meth = '0;
    logic [31:0] heard_v    = '0;
    logic        word_rdy   = 1'b0;

    logic        heard_rdy;
    logic        word_ena;
    logic [31:0] word_data;
    logic        word_last;
    logic        ovf;

    always #5 clk = ~clk;

    heard_word_serializer #(
        .DEPTH     (DEPTH),
        .METHOD_ID (16'h0001)
    ) dut (
        .CLK                   (clk),
        .nRST                  (n_rst),
        .indication_heard__ENA (heard_ena),
        .indication_heard_meth (heard_meth),
        .indication_heard_v    (heard_v),
        .indication_heard__RDY (heard_rdy),
        .word__ENA             (word_ena),
        .word_data             (word_data),
        .word_last             (word_last),
        .word__RDY             (word_rdy),
        .err_overflow          (ovf)
    );

    // Model: queued messages, position inside the head message, sticky overflow.
    logic [63:0] model_q[$];
    int          model_pos = 0;
    bit          model_ovf = 0;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [35:0] exp_v;
    logic [35:0] obs;
    assign obs = {word_ena, word_last, heard_rdy, ovf, word_data};

    // Expected {ena, last, rdy, ovf, data} for the current cycle.
    function automatic logic [35:0] expect_now();
        logic [31:0] d = '0;
        logic        l = 1'b0;
        logic        e = 1'b0;
        logic        r = (model_q.size() != DEPTH);
        if (model_q.size() != 0) begin
            e = word_rdy;
            case (model_pos)
                0:       d = HDR;
                1:       d = model_q[0][63:32];
                default: begin d = model_q[0][31:0]; l = 1'b1; end
            endcase
        end
        return {e, l, r, model_ovf, d};
    endfunction

    task automatic apply(input logic ena, input logic [31:0] m, input logic [31:0] v,
                         input logic wr);
        heard_ena  = ena;
        heard_meth = m;
        heard_v    = v;
        word_rdy   = wr;
        #1;
        exp_v = expect_now();
    endtask

    // Clock one edge and advance the model by the message-level rules.
    task automatic tick();
        bit was_full;
        @(posedge clk);
        was_full = (model_q.size() == DEPTH);
        if (model_q.size() != 0 && word_rdy) begin
            if (model_pos == 2) begin
                void'(model_q.pop_front());
                model_pos = 0;
            end else begin
                model_pos++;
            end
        end
        if (heard_ena) begin
            if (!was_full) model_q.push_back({heard_meth, heard_v});
            else           model_ovf = 1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        apply(1'b0, '0, '0, 1'b1);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL reset_held: got %h expected %h", obs, exp_v);
        end
        @(negedge clk);
        n_rst = 1'b1;
        apply(1'b0, '0, '0, 1'b1);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL reset_released: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_single();
        apply(1'b1, 32'h1, 32'hDEAD_BEEF, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, '0, '0, 1'b1);
            n_vec++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL single word %0d: got %h expected %h", i, obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && model_q.size() != 0; i++) begin
            apply(1'b0, '0, '0, 1'b1);
            n_vec++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL %s drain %0d: got %h expected %h", name, i, obs, exp_v);
            end
            tick();
        end
        apply(1'b0, '0, '0, 1'b1);
        n_vec++;
        if (obs !== exp_v || model_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s drained: got %h expected %h, %0d left in model",
                     name, obs, exp_v, model_q.size());
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 6; i++) begin
            apply(i < 5, $urandom, $urandom, 1'b0);
            n_vec++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL fill step %0d: got %h expected %h", i, obs, exp_v);
            end
            tick();
        end
        drain("fill");
    endtask

    task automatic test_backpressure();
        apply(1'b1, $urandom, $urandom, 1'b0);
        tick();
        for (int i = 0; i < 12; i++) begin
            apply(1'b0, '0, '0, logic'(i % 2));
            n_vec++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL backpressure cycle %0d: got %h expected %h", i, obs, exp_v);
            end
            tick();
        end
        drain("backpressure");
    endtask

    task automatic test_concurrency();
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, $urandom, $urandom, 1'b0);
            tick();
        end
        // HDR, MSG, then VAL with a simultaneous push, then the next header.
        for (int i = 0; i < 4; i++) begin
            apply(i == 2, $urandom, $urandom, 1'b1);
            n_vec++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL concurrency cycle %0d: got %h expected %h", i, obs, exp_v);
            end
            tick();
        end
        drain("concurrency");
    endtask

    task automatic test_wrap();
        int next_v = 0;
        int seen_v = 0;
        for (int i = 0; i < 150 && !(next_v == 10 && model_q.size() == 0); i++) begin
            logic ena;
            ena = (next_v < 10) && (model_q.size() != DEPTH);
            apply(ena, $urandom, next_v, 1'b1);
            if (ena) next_v++;
            n_vec++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL wrap cycle %0d: got %h expected %h", i, obs, exp_v);
            end
            if (word_ena && word_last) begin
                n_vec++;
                if (word_data !== seen_v) begin
                    n_bad++;
                    $display("FAIL wrap last word: got v=%0d expected v=%0d", word_data, seen_v);
                end
                seen_v++;
            end
            tick();
        end
        n_vec++;
        if (seen_v != 10) begin
            n_bad++;
            $display("FAIL wrap count: got %0d messages expected 10", seen_v);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            apply($urandom_range(0, 2) != 0, $urandom, $urandom, $urandom_range(0, 1) == 1);
            n_vec++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL random cycle %0d: got %h expected %h", i, obs, exp_v);
            end
            tick();
        end
        drain("random");
    endtask

    task automatic test_async_reset();
        apply(1'b1, 32'hA5A5_0001, 32'h1234_5678, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, '0, '0, 1'b1);
            tick();
        end
        // Head message now at its VAL word; reset between edges.
        #2;
        n_rst = 1'b0;
        #1;
        model_q.delete();
        model_pos = 0;
        model_ovf = 0;
        exp_v = expect_now();
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL async_reset: got %h expected %h", obs, exp_v);
        end
        @(negedge clk);
        n_rst = 1'b1;
        apply(1'b1, 32'h0000_00AA, 32'h0000_00BB, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, '0, '0, 1'b1);
            n_vec++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL after_reset word %0d: got %h expected %h", i, obs, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_backpressure();
        test_concurrency();
        test_wrap();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/heard_word_serializer.md
Name: heard_word_serializer

Overview:
- Downstream neighbour of the echo top level. It consumes the top level's exported indication heard method, which carries meth and v.
- Each accepted message is buffered in a small FIFO and emitted as a 3-word, 32-bit stream toward the host transport.
- It decouples host-side backpressure from the Echo indication path.
- Rule-style handshake: the callee exports __RDY, and the caller asserts __ENA only while __RDY is high.

Parameters:
- DEPTH, 4, message FIFO depth in entries; power of two, minimum 2.
- METHOD_ID, 16'h0001, method index placed in the header word.
- MSG_WORDS, 3, words per message; fixed and not overridable.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- nRST  input  1  reset; asynchronous assert, active-low.
- indication$heard__ENA  input  1  enqueue strobe from the upstream Echo indication.
- indication$heard$meth  input  32  message field meth.
- indication$heard$v  input  32  message field v.
- indication$heard__RDY  output  1  high when the FIFO can accept a message.
- word__ENA  output  1  word transfer strobe to the host stream.
- word$data  output  32  current word.
- word$last  output  1  high on the final word of a message.
- word__RDY  input  1  host can accept a word this cycle.
- err$overflow  output  1  sticky flag: ENA was seen while RDY was low.

Behaviour:
- Reset is asynchronous: while nRST is low, all of the following are cleared immediately, independent of CLK:
  - write pointer, read pointer, count, word index and err$overflow go to 0;
  - indication$heard__RDY = 1 after reset, because the FIFO is empty;
  - word__ENA = 0, word$last = 0, word$data = 0.
- FIFO storage: DEPTH entries of {meth, v}, 64 bits each. Storage contents are not reset.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- indication$heard__RDY = (count != DEPTH). It is a combinational function of registered state and does not depend on same-cycle pop.
  - Consequence: when full, a pop and a push never occur in the same cycle.
- Push: when indication$heard__ENA and RDY are both high, store {meth, v} at wptr, then wptr+1 and count+1.
- Push with ENA high and RDY low: data is dropped and err$overflow is set to 1 on the next edge. err$overflow holds until reset.
- Output word selection, with entry = fifo[rptr] and widx = 0..2:
  - widx 0: data = {16'd3, METHOD_ID}, last = 0.
  - widx 1: data = entry.meth, last = 0.
  - widx 2: data = entry.v, last = 1.
- When count == 0, word$data = 0 and word$last = 0.
- word__ENA = (count != 0) & word__RDY, combinational. A word transfers in every cycle that word__ENA is high.
- Word-index state machine:
  - States: IDLE (count == 0), HDR (widx 0), MSG (widx 1), VAL (widx 2).
  - Transitions happen only on a transfer: HDR→MSG→VAL.
  - On a VAL transfer: pop (rptr+1, count−1) and widx returns to 0. The next state is HDR if count is still nonzero after any simultaneous push, otherwise IDLE.
- Latency: a message pushed at edge N can emit its header word during cycle N+1, if the FIFO was empty and word__RDY is high. No bypass path exists.
- Simultaneous push and pop (count not full): count is unchanged, and both pointers advance.
- Backpressure: word__RDY low holds widx, rptr and data stable. The same word is presented when word__RDY returns high.
- A message is never split across a reset. If reset occurs mid-message, the partial message and all queued messages are discarded.
- Throughput: at most 1 message per 3 cycles is drained. The upstream side sees RDY low once DEPTH messages are pending.

Decomposition:
- Shared package contains:
  - typedef heard_msg_t {meth[31:0], v[31:0]};
  - the widx encoding constants HDR=0, MSG=1, VAL=2;
  - the header length constant 16'd3.
- One sub-module is natural: msg_fifo, a generic DEPTH×64 register FIFO with push/pop, full/empty and count. The serializer FSM stays in the top module.

Test Plan:
1. Reset then single message: meth=32'h1, v=32'hDEADBEEF, word__RDY=1.
   - Cycles 1–3 carry 0x00030001, 0x00000001, 0xDEADBEEF.
   - last is high only on the third word; RDY stays 1 throughout.
2. Fill: 4 back-to-back pushes with word__RDY=0.
   - RDY drops to 0 after the 4th push.
   - A 5th ENA sets err$overflow=1 and the FIFO still holds exactly 4 messages.
3. Backpressure: toggle word__RDY every cycle during a message.
   - Each word is repeated until transferred; the sequence and values are unchanged.
4. Concurrency: push a new message in the same cycle as a VAL transfer, with count=2.
   - count stays 2; the next word is the header of the following message.
5. Wrap-around: push and drain 10 messages (v=0..9) with DEPTH=4.
   - All 30 words are in order; v values 0..9 appear on the last words.
6. Async reset mid-message: drop nRST between edges after the MSG word.
   - Outputs clear immediately: word__ENA=0, RDY=1, err$overflow=0.
   - After release, a new message restarts at the header.
